mult_div_unit: RTL and testbench

- Multi-cycle multiply/divide unit. Sits directly downstream of the register file read ports, in parallel with the single-cycle ALU.
- Consumes Out1/Out2 as operands A/B and produces a 64-bit HI/LO result. HI/LO feed the write-data mux for register writeback.
- Iterative, one bit per clock. A Start/Busy/Done handshake stalls the issuing control logic.

---
 rtl/mult_div_unit.sv | 158 +++++++++++++++
 tb/tb_mult_div_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: one bit per clock, HI/LO results.
// Optional MDU_EARLY_OUT_EN ends a multiply once the multiplier runs out.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             DivByZero
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               is_sgn;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_raw;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   dvsr;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;

  logic               in_sgn;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc_n;
  logic [2*WIDTH-1:0] mcand_n;
  logic [WIDTH-1:0]   mplier_n;
  logic [WIDTH:0]     rem_sh;
  logic               ge;
  logic [WIDTH-1:0]   rem_n;
  logic [WIDTH-1:0]   quo_n;
  logic               finish;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;
  logic               div0;

  // Operand magnitudes at accept; -2^(W-1) maps to unsigned 2^(W-1).
  always_comb begin
    in_sgn = ~Op[0];
    a_mag  = (in_sgn & A[WIDTH-1]) ? -A : A;
    b_mag  = (in_sgn & B[WIDTH-1]) ? -B : B;
  end

  // One shift-add step and one restoring-divide step, plus final sign fix.
  always_comb begin
    acc_n    = mplier[0] ? acc + mcand : acc;
    mcand_n  = mcand << 1;
    mplier_n = mplier >> 1;
    rem_sh   = {rem, quo[WIDTH-1]};
    ge       = rem_sh >= {1'b0, dvsr};
    rem_n    = ge ? WIDTH'(rem_sh - {1'b0, dvsr})
                  : rem_sh[WIDTH-1:0];
    quo_n    = {quo[WIDTH-2:0], ge};
`ifdef MDU_EARLY_OUT_EN
    finish   = (cnt == LAST) | (~is_div & (mplier_n == '0));
`else
    finish   = (cnt == LAST);
`endif
    prod     = (is_sgn & (a_neg ^ b_neg)) ? -acc_n : acc_n;
    q_fix    = (is_sgn & (a_neg ^ b_neg)) ? -quo_n : quo_n;
    r_fix    = (is_sgn & a_neg) ? -rem_n : rem_n;
    div0     = (dvsr == '0);
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      HI        <= '0;
      LO        <= '0;
      cnt       <= '0;
      is_div    <= 1'b0;
      is_sgn    <= 1'b0;
      a_neg     <= 1'b0;
      b_neg     <= 1'b0;
      a_raw     <= '0;
      mplier    <= '0;
      quo       <= '0;
      rem       <= '0;
      dvsr      <= '0;
      acc       <= '0;
      mcand     <= '0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (Start) begin
            state     <= RUN;
            Busy      <= 1'b1;
            DivByZero <= 1'b0;
            cnt       <= '0;
            is_div    <= Op[1];
            is_sgn    <= in_sgn;
            a_neg     <= in_sgn & A[WIDTH-1];
            b_neg     <= in_sgn & B[WIDTH-1];
            a_raw     <= A;
            acc       <= '0;
            mcand     <= {{WIDTH{1'b0}}, a_mag};
            mplier    <= b_mag;
            rem       <= '0;
            quo       <= a_mag;
            dvsr      <= b_mag;
          end
        end
        RUN: begin
          cnt    <= cnt + 1'b1;
          acc    <= acc_n;
          mcand  <= mcand_n;
          mplier <= mplier_n;
          rem    <= rem_n;
          quo    <= quo_n;
          if (finish) begin
            state <= DONE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
            cnt   <= '0;
            if (is_div) begin
              HI        <= div0 ? a_raw : r_fix;
              LO        <= div0 ? '1 : q_fix;
              DivByZero <= div0;
            end else begin
              HI        <= prod[2*WIDTH-1:WIDTH];
              LO        <= prod[WIDTH-1:0];
              DivByZero <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases plus random ops vs arithmetic model.
// Expected latency follows MDU_EARLY_OUT_EN when the macro is defined.
module tb_mult_div_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Busy;
  logic        Done;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        DivByZero;

  int checks = 0;
  int failures = 0;

  mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Start(Start),
    .Op(Op),
    .A(A),
    .B(B),
    .Busy(Busy),
    .Done(Done),
    .HI(HI),
    .LO(LO),
    .DivByZero(DivByZero)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void ref_model(input logic [1:0] op,
                                    input logic [31:0] a,
                                    input logic [31:0] b,
                                    output logic [31:0] hi,
                                    output logic [31:0] lo,
                                    output logic dz);
    longint p;
    logic [63:0] pu;
    int q;
    int r;
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin
        p = longint'($signed(a)) * longint'($signed(b));
        {hi, lo} = p;
      end
      2'b01: begin
        pu = {32'h0, a} * {32'h0, b};
        {hi, lo} = pu;
      end
      2'b10: begin
        if (b == 0) begin
          lo = 32'hFFFFFFFF; hi = a; dz = 1'b1;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          lo = 32'h80000000; hi = 0;
        end else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          lo = q; hi = r;
        end
      end
      default: begin
        if (b == 0) begin
          lo = 32'hFFFFFFFF; hi = a; dz = 1'b1;
        end else begin
          lo = a / b; hi = a % b;
        end
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
    int n;
    logic [31:0] m;
    n = 32;
`ifdef MDU_EARLY_OUT_EN
    if (!op[1]) begin
      m = (op == 2'b00 && b[31]) ? -b : b;
      n = 1;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    end
`else
    m = b;
    if (op[1] && m[0]) n = 32;
`endif
    return n;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
    logic [31:0] eh;
    logic [31:0] el;
    logic ed;
    int cyc;
    ref_model(op, a, b, eh, el, ed);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge Clk); #1;
    Start = 1'b0;
    Op = 2'($urandom); A = $urandom; B = $urandom;
    chk({tag, " busy"}, 32'(Busy), 32'd1);
    chk({tag, " dz_clr"}, 32'(DivByZero), 32'd0);
    cyc = 0;
    while (!Done && cyc < 40) begin
      @(posedge Clk); #1;
      cyc++;
    end
    chk({tag, " lat"}, 32'(cyc), 32'(exp_lat(op, b)));
    chk({tag, " hi"}, HI, eh);
    chk({tag, " lo"}, LO, el);
    chk({tag, " dz"}, 32'(DivByZero), 32'(ed));
    chk({tag, " busy_end"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    int cyc;
    int seen;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] edge_v [4];

    repeat (3) @(posedge Clk);
    #1;
    chk("rst busy", 32'(Busy), 32'd0);
    chk("rst done", 32'(Done), 32'd0);
    chk("rst hi", HI, 32'd0);
    chk("rst lo", LO, 32'd0);
    chk("rst dz", 32'(DivByZero), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    run_op(2'b00, -32'sd2, 32'd1300, "mult_neg");
    chk("mult_neg hi_c", HI, 32'hFFFFFFFF);
    chk("mult_neg lo_c", LO, 32'hFFFFF5D8);
    run_op(2'b01, 32'hFFFFFFFF, 32'd2, "multu_big");
    chk("multu_big hi_c", HI, 32'h00000001);
    run_op(2'b00, 32'hFFFFFFFF, 32'd2, "mult_big");
    chk("mult_big hi_c", HI, 32'hFFFFFFFF);
    run_op(2'b10, -32'sd2000, 32'd3, "div_neg");
    chk("div_neg lo_c", LO, 32'hFFFFFD66);
    chk("div_neg hi_c", HI, 32'hFFFFFFFE);
    run_op(2'b11, 32'd2000, 32'd3, "divu");
    run_op(2'b11, 32'd7, 32'd0, "divu_z");
    chk("divu_z lo_c", LO, 32'hFFFFFFFF);
    run_op(2'b00, 32'd3, 32'd4, "mult_after_z");
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    run_op(2'b10, 32'hFFFFFFF9, 32'd0, "div_z_neg");
    run_op(2'b00, 32'h80000000, 32'h80000000, "mult_min");
    run_op(2'b10, 32'd7, -32'sd2, "div_pos_neg");

    // Start during RUN must be ignored
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Start = 1'b1; Op = 2'b00; A = 32'd5; B = 32'd6;
    @(posedge Clk); #1;
    Start = 1'b0;
    cyc = 0;
    while (!Done && cyc < 40) begin
      if (cyc == ((exp_lat(2'b00, 32'd6) > 10) ? 10 : 1)) begin
        @(negedge Clk);
        Start = 1'b1; Op = 2'b10; A = 32'd100; B = 32'd7;
      end
      @(posedge Clk); #1;
      Start = 1'b0;
      cyc++;
    end
    chk("ign lat", 32'(cyc), 32'(exp_lat(2'b00, 32'd6)));
    chk("ign lo", LO, 32'd30);
    chk("ign hi", HI, 32'd0);
    @(posedge Clk); #1;
    chk("ign idle", 32'(Busy), 32'd0);

    // Reset mid-operation discards the divide
    @(negedge Clk);
    Start = 1'b1; Op = 2'b10; A = 32'd100; B = 32'd7;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (14) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk); #1;
    chk("mid_rst busy", 32'(Busy), 32'd0);
    chk("mid_rst done", 32'(Done), 32'd0);
    chk("mid_rst hi", HI, 32'd0);
    chk("mid_rst lo", LO, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge Clk); #1;
      if (Done) seen = 1;
    end
    chk("mid_rst no_done", 32'(seen), 32'd0);
    run_op(2'b10, 32'd100, 32'd7, "reissue");
    chk("reissue lo_c", LO, 32'd14);
    chk("reissue hi_c", HI, 32'd2);
    run_op(2'b00, 32'd9, 32'd1, "mult_9x1");

    edge_v[0] = 32'h0;
    edge_v[1] = 32'h80000000;
    edge_v[2] = 32'hFFFFFFFF;
    edge_v[3] = 32'h1;
    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)]
                                       : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)]
                                       : $urandom;
      if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(0, 31);
      repeat ($urandom_range(0, 2)) @(posedge Clk);
      run_op(2'($urandom), ra, rb, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
